meta_update_queue: RTL and testbench



---
 rtl/meta_update_queue.sv | 167 ++++++++++++++++
 tb/tb_meta_update_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_update_queue.sv
// meta_update_queue
//
// In-order tracking queue for predicted conditional branches. Fetch allocates
// one entry per predicted branch, recording the meta predictor table index and
// the taken guesses of the global and local component predictors. Execute
// resolves branches oldest-first. Each successful resolve produces exactly one
// registered update strobe toward the meta predictor table, so the table sees
// one write per branch.
//
// Parameters:
//   DEPTH  number of in-flight branch entries (power of two, >= 2)
//   IDX_W  width of the meta predictor table index
//
// Ports:
//   clk                 clock
//   rst                 asynchronous active-high reset
//   alloc_valid         fetch requests an entry this cycle
//   alloc_idx           meta table index for the new branch
//   alloc_global_pred   global predictor's taken guess
//   alloc_local_pred    local predictor's taken guess
//   alloc_ready         queue can accept an allocation (0 while rst is high)
//   resolve_valid       oldest in-flight branch resolves this cycle
//   resolve_taken       actual direction of the resolving branch
//   flush               discard all unresolved entries (redirect)
//   upd_write           one-cycle write strobe to the meta table
//   upd_idx             table index to update (holds when upd_write=0)
//   upd_global_outcome  1 = global guess matched the actual direction
//   upd_local_outcome   1 = local guess matched the actual direction
//   count               current occupancy
//   resolve_err         one-cycle pulse: resolve seen while the queue was empty

module meta_update_queue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             alloc_global_pred,
  input  logic             alloc_local_pred,
  output logic             alloc_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             upd_write,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_global_outcome,
  output logic             upd_local_outcome,
  output logic [CNT_W-1:0] count,
  output logic             resolve_err
);

  // Entry storage. Not reset: head/tail/count define which slots are live.
  logic [IDX_W-1:0] idx_mem   [DEPTH];
  logic             gpred_mem [DEPTH];
  logic             lpred_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             upd_write_reg, upd_write_next;
  logic [IDX_W-1:0] upd_idx_reg, upd_idx_next;
  logic             upd_global_reg, upd_global_next;
  logic             upd_local_reg, upd_local_next;
  logic             resolve_err_reg, resolve_err_next;

  logic is_empty;
  logic is_full;
  logic push;
  logic pop;

  logic [IDX_W-1:0] head_idx;
  logic             head_gpred;
  logic             head_lpred;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CNT_W'(DEPTH));

  // Readiness looks only at the registered occupancy; a resolve in the same
  // cycle does not free a slot for an allocation until the next cycle.
  assign alloc_ready = !is_full && !rst;

  // A flushed cycle never accepts a new entry; the resolve still pops first.
  assign push = alloc_valid && alloc_ready && !flush;
  assign pop  = resolve_valid && !is_empty;

  assign head_idx   = idx_mem[head_reg];
  assign head_gpred = gpred_mem[head_reg];
  assign head_lpred = lpred_mem[head_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail_reg]   <= alloc_idx;
      gpred_mem[tail_reg] <= alloc_global_pred;
      lpred_mem[tail_reg] <= alloc_local_pred;
    end
  end

  // Pointer and occupancy update. Pointers wrap naturally because DEPTH is a
  // power of two.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (pop) begin
        head_next = head_reg + PTR_W'(1);
      end
      if (push) begin
        tail_next = tail_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Update strobe generation. Payload holds its last value between strobes.
  always_comb begin
    upd_write_next   = pop;
    upd_idx_next     = upd_idx_reg;
    upd_global_next  = upd_global_reg;
    upd_local_next   = upd_local_reg;
    resolve_err_next = resolve_valid && is_empty;
    if (pop) begin
      upd_idx_next    = head_idx;
      upd_global_next = (head_gpred == resolve_taken);
      upd_local_next  = (head_lpred == resolve_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      upd_write_reg   <= 1'b0;
      upd_idx_reg     <= '0;
      upd_global_reg  <= 1'b0;
      upd_local_reg   <= 1'b0;
      resolve_err_reg <= 1'b0;
    end else begin
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      count_reg       <= count_next;
      upd_write_reg   <= upd_write_next;
      upd_idx_reg     <= upd_idx_next;
      upd_global_reg  <= upd_global_next;
      upd_local_reg   <= upd_local_next;
      resolve_err_reg <= resolve_err_next;
    end
  end

  assign count              = count_reg;
  assign upd_write          = upd_write_reg;
  assign upd_idx            = upd_idx_reg;
  assign upd_global_outcome = upd_global_reg;
  assign upd_local_outcome  = upd_local_reg;
  assign resolve_err        = resolve_err_reg;

endmodule

// File: tb/tb_meta_update_queue.sv
// Randomized and directed bench for meta_update_queue against a queue-based
// reference model of the branch tracking rules.

module tb_meta_update_queue;

  localparam int DEPTH = 8;
  localparam int IDX_W = 10;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_global_pred;
  logic             alloc_local_pred;
  logic             alloc_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             upd_write;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_global_outcome;
  logic             upd_local_outcome;
  logic [CNT_W-1:0] count;
  logic             resolve_err;

  meta_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_valid        (alloc_valid),
    .alloc_idx          (alloc_idx),
    .alloc_global_pred  (alloc_global_pred),
    .alloc_local_pred   (alloc_local_pred),
    .alloc_ready        (alloc_ready),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .upd_write          (upd_write),
    .upd_idx            (upd_idx),
    .upd_global_outcome (upd_global_outcome),
    .upd_local_outcome  (upd_local_outcome),
    .count              (count),
    .resolve_err        (resolve_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             g;
    logic             l;
  } br_t;

  br_t model_q[$];

  logic             exp_write;
  logic [IDX_W-1:0] exp_idx;
  logic             exp_g;
  logic             exp_l;
  logic             exp_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("upd_write", 32'(upd_write), 32'(exp_write));
    check("upd_idx", 32'(upd_idx), 32'(exp_idx));
    check("upd_global", 32'(upd_global_outcome), 32'(exp_g));
    check("upd_local", 32'(upd_local_outcome), 32'(exp_l));
    check("resolve_err", 32'(resolve_err), 32'(exp_err));
    check("count", 32'(count), model_q.size());
    check("alloc_ready", 32'(alloc_ready), 32'(model_q.size() != DEPTH));
  endtask

  // One clock of stimulus: drive at negedge, advance the model, compare
  // just after the following posedge.
  task automatic step(input logic av, input logic [IDX_W-1:0] ai, input logic ag,
                      input logic al, input logic rv, input logic rt, input logic fl);
    br_t e;
    br_t n;
    int  sz;
    bit  ready;
    @(negedge clk);
    alloc_valid       = av;
    alloc_idx         = ai;
    alloc_global_pred = ag;
    alloc_local_pred  = al;
    resolve_valid     = rv;
    resolve_taken     = rt;
    flush             = fl;

    sz    = model_q.size();
    ready = (sz != DEPTH);
    exp_err   = rv && (sz == 0);
    exp_write = 1'b0;
    if (rv && sz > 0) begin
      e = model_q.pop_front();
      exp_write = 1'b1;
      exp_idx   = e.idx;
      exp_g     = (e.g == rt);
      exp_l     = (e.l == rt);
    end
    if (fl) begin
      model_q.delete();
    end else if (av && ready) begin
      n.idx = ai;
      n.g   = ag;
      n.l   = al;
      model_q.push_back(n);
    end

    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d av=%0b idx=0x%03h rv=%0b rt=%0b fl=%0b -> wr=%0b uidx=0x%03h g=%0b l=%0b err=%0b cnt=%0d",
             cyc, av, ai, rv, rt, fl, upd_write, upd_idx, upd_global_outcome,
             upd_local_outcome, resolve_err, count);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [IDX_W-1:0] ai, input logic ag, input logic al);
    step(1'b1, ai, ag, al, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rt, 1'b0);
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_write = 1'b0;
    exp_idx   = '0;
    exp_g     = 1'b0;
    exp_l     = 1'b0;
    exp_err   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_idx = '0;
    alloc_global_pred = 1'b0;
    alloc_local_pred = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush = 1'b0;
    clear_model();

    // Reset state while rst is held: alloc_ready forced low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(alloc_ready), 0);
    check("rst_upd_write", 32'(upd_write), 0);
    check("rst_upd_idx", 32'(upd_idx), 0);
    check("rst_err", 32'(resolve_err), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(alloc_ready), 1);

    // 1: basic alloc then resolve two cycles later.
    alloc(10'h005, 1'b1, 1'b0);
    idle();
    resolve(1'b1);
    idle();

    // 2: fill to DEPTH, ignored 9th alloc, drain in order.
    for (int i = 0; i < DEPTH; i++) alloc(IDX_W'(i), i[0], i[1]);
    alloc(10'h3FF, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) resolve(i[2]);
    idle();

    // Full with simultaneous alloc+resolve: only the resolve happens.
    for (int i = 0; i < DEPTH; i++) alloc(IDX_W'(10'h040 + i), 1'b0, 1'b1);
    step(1'b1, 10'h3FE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) resolve(1'b0);
    idle();

    // 3: alloc+resolve at count=3, then drain with no gap.
    for (int i = 0; i < 3; i++) alloc(IDX_W'(10'h080 + i), 1'b1, 1'b1);
    step(1'b1, 10'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) resolve(1'b1);
    idle();

    // Empty with simultaneous alloc+resolve: alloc accepted, resolve errors.
    step(1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    resolve(1'b0);
    idle();

    // 4: flush with head resolve, then resolve on an empty queue.
    for (int i = 0; i < 5; i++) alloc(IDX_W'(10'h0C0 + i), 1'b1, 1'b0);
    step(1'b1, 10'h2AA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    resolve(1'b1);
    idle();

    // 5: pointer wrap with steady-state alloc+resolve.
    alloc(10'h200, 1'b0, 1'b0);
    alloc(10'h201, 1'b1, 1'b1);
    for (int i = 2; i < 20; i++)
      step(1'b1, IDX_W'(10'h200 + i), i[0], i[1], 1'b1, i[2], 1'b0);
    resolve(1'b0);
    resolve(1'b1);
    idle();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), IDX_W'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 5), 1'($urandom), ($urandom_range(0, 49) == 0));
    end
    idle();

    // 6: async reset after a resolve, before the strobe edge.
    for (int i = 0; i < 3; i++) alloc(IDX_W'(10'h300 + i), 1'b1, 1'b0);
    @(negedge clk);
    alloc_valid = 1'b0;
    flush = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_ready", 32'(alloc_ready), 0);
    check("arst_upd_write", 32'(upd_write), 0);
    @(posedge clk);
    #1;
    check("arst_edge_upd_write", 32'(upd_write), 0);
    check("arst_edge_ready", 32'(alloc_ready), 0);
    check("arst_edge_count", 32'(count), 0);
    @(negedge clk);
    resolve_valid = 1'b0;
    rst = 1'b0;
    clear_model();
    #1;
    check("arst_release_ready", 32'(alloc_ready), 1);
    idle();
    alloc(10'h0AB, 1'b0, 1'b1);
    resolve(1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
